// File: rtl/sm_mem_arbiter_pkg.sv
// Shared types and constants for the schoolRISCV data-RAM arbiter.
package sm_mem_arbiter_pkg;

    // Which master owns an in-flight read.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Byte-enable patterns for sw / sh / sb on a 32-bit word.
    localparam logic [3:0] BE_W  = 4'b1111;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;

    // Width of the starvation counter (MAX_WAIT up to 15).
    localparam int WAIT_W = 4;

endpackage

// File: rtl/sm_mem_arb_starve.sv
// Starvation guard for a low-priority requester: counts consecutive denied
// cycles and raises force_o once the count reaches MAX_WAIT.
module sm_mem_arb_starve
    import sm_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              gnt_i,
    output logic              force_o,
    output logic [WAIT_W-1:0] cnt_o
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Next count: restart on grant or dropped request, else count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Force depends only on the registered count, so it never loops through the grant.
    assign force_o = req_i && (cnt_q == MAX_CNT);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sm_mem_arbiter.sv
// Two-port arbiter for the single-port data RAM: CPU (port 0) has fixed
// priority, the debug/loader master (port 1) is forced in after MAX_WAIT
// denied cycles. Read data comes back one cycle after grant to its owner.
// Handshake: mN_req is held until mN_gnt; a grant accepts the access in that
// same cycle; mN_rvalid pulses for one cycle exactly one cycle after a read grant.
module sm_mem_arbiter
    import sm_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [AW-1:0]     m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [AW-1:0]     m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [AW-1:0]     ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [WAIT_W-1:0] dbg_wait_cnt_o
);

    logic   force_m1;
    logic   rd_pend_q, rd_pend_d;
    owner_e rd_owner_q, rd_owner_d;

    sm_mem_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (m1_req),
        .gnt_i   (m1_gnt),
        .force_o (force_m1),
        .cnt_o   (dbg_wait_cnt_o)
    );

    // Grant selection: forced port 1, else port 0, else port 1.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (force_m1) begin
            m1_gnt = 1'b1;
        end else if (m0_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end
    end

    // RAM port mux: follows the granted master, idle-zero otherwise.
    always_comb begin
        ram_en    = m0_gnt | m1_gnt;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (m1_gnt) begin
            ram_we    = m1_we;
            ram_be    = m1_be;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end else if (m0_gnt) begin
            ram_we    = m0_we;
            ram_be    = m0_be;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end
    end

    // Capture every granted read so its data can be routed back next cycle.
    always_comb begin
        rd_pend_d  = ram_en & ~ram_we;
        rd_owner_d = m1_gnt ? OWN_DBG : OWN_CPU;
    end

    // Read-tracking registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = rd_pend_q && (rd_owner_q == OWN_CPU);
    assign m1_rvalid = rd_pend_q && (rd_owner_q == OWN_DBG);
    assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Directed bench for sm_mem_arbiter with a behavioural byte-enabled RAM.
// RAM word i is preloaded with {8'hC0, i, 8'h5A, i}.
module tb_sm_mem_arbiter;
    import sm_mem_arbiter_pkg::*;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [3:0]    m0_be, m1_be;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [3:0]    dbg_wait_cnt;

    logic [31:0]   mem [0:255];
    int            total;
    int            bad;

    sm_mem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_be          (m0_be),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_be          (m1_be),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_be         (ram_be),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .dbg_wait_cnt_o (dbg_wait_cnt)
    );

    // Clock: posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM with byte enables, read latency 1.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance to 1 time unit after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic drive0(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                          input logic [31:0] wdata);
        m0_req = 1'b1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic drive1(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                          input logic [31:0] wdata);
        m1_req = 1'b1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ram_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 8'h5A, 8'(i)};
        idle();
        rst_n = 1'b0;
        repeat (2) tick();

        // Reset state.
        chk("rst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        chk("rst_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        chk("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        chk("rst_wait_cnt", {28'h0, dbg_wait_cnt}, 32'h0);
        // Grant is combinational even while reset is held.
        drive0(1'b0, BE_W, 8'h10, 32'h0);
        #1;
        chk("rst_comb_gnt", {31'h0, m0_gnt}, 32'h1);
        idle();
        #1;
        rst_n = 1'b1;
        tick();

        // m0 read 0x10 alone.
        drive0(1'b0, BE_W, 8'h10, 32'h0);
        #1;
        chk("rd0_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        chk("rd0_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        chk("rd0_ram_en", {31'h0, ram_en}, 32'h1);
        chk("rd0_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rd0_ram_addr", {24'h0, ram_addr}, 32'h10);
        tick();
        idle();
        #1;
        chk("rd0_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        chk("rd0_m0_rdata", m0_rdata, 32'hC0105A10);
        chk("rd0_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        chk("rd0_m1_rdata", m1_rdata, 32'h0);
        chk("rd0_idle_en", {31'h0, ram_en}, 32'h0);
        tick();

        // m1 store byte 2 of word 0x05.
        drive1(1'b1, BE_B2, 8'h05, 32'h00AB0000);
        #1;
        chk("sb_m1_gnt", {31'h0, m1_gnt}, 32'h1);
        chk("sb_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        chk("sb_ram_we", {31'h0, ram_we}, 32'h1);
        chk("sb_ram_be", {28'h0, ram_be}, 32'h4);
        chk("sb_ram_addr", {24'h0, ram_addr}, 32'h05);
        chk("sb_ram_wdata", ram_wdata, 32'h00AB0000);
        tick();
        idle();
        drive0(1'b0, BE_W, 8'h05, 32'h0);
        #1;
        chk("sb_no_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        chk("sb_no_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        tick();
        idle();
        #1;
        chk("sb_readback", m0_rdata, 32'hC0AB5A05);
        tick();

        // Back-to-back reads: m0 @0x01 then m1 @0x02.
        drive0(1'b0, BE_W, 8'h01, 32'h0);
        tick();
        idle();
        drive1(1'b0, BE_W, 8'h02, 32'h0);
        #1;
        chk("b2b_m1_gnt", {31'h0, m1_gnt}, 32'h1);
        chk("b2b_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        chk("b2b_m0_rdata", m0_rdata, 32'hC0015A01);
        chk("b2b_m1_rvalid_a", {31'h0, m1_rvalid}, 32'h0);
        tick();
        idle();
        #1;
        chk("b2b_m1_rvalid_b", {31'h0, m1_rvalid}, 32'h1);
        chk("b2b_m1_rdata", m1_rdata, 32'hC0025A02);
        chk("b2b_m0_rvalid_b", {31'h0, m0_rvalid}, 32'h0);
        tick();

        // Continuous contention: m0 four times, m1 on the fifth, repeating.
        drive0(1'b0, BE_W, 8'h20, 32'h0);
        drive1(1'b0, BE_W, 8'h30, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_m1_gnt_%0d", i), {31'h0, m1_gnt}, {31'h0, (i % 5) == 4});
            chk($sformatf("cont_m0_gnt_%0d", i), {31'h0, m0_gnt}, {31'h0, (i % 5) != 4});
            chk($sformatf("cont_wait_%0d", i), {28'h0, dbg_wait_cnt}, 32'(i % 5));
            if (i > 0) begin
                chk($sformatf("cont_m1_rvalid_%0d", i), {31'h0, m1_rvalid},
                    {31'h0, ((i - 1) % 5) == 4});
            end
            tick();
        end
        idle();
        #1;
        chk("cont_last_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
        chk("cont_last_m1_rdata", m1_rdata, 32'hC0305A30);
        tick();

        // m1 drops after 3 denials, then re-asserts: needs 4 fresh denials.
        drive0(1'b0, BE_W, 8'h20, 32'h0);
        drive1(1'b0, BE_W, 8'h30, 32'h0);
        repeat (3) tick();
        m1_req = 1'b0;
        #1;
        chk("drop_wait_3", {28'h0, dbg_wait_cnt}, 32'h3);
        chk("drop_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        tick();
        m1_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("redo_wait_%0d", i), {28'h0, dbg_wait_cnt}, 32'(i));
            chk($sformatf("redo_m1_gnt_%0d", i), {31'h0, m1_gnt}, {31'h0, i == 4});
            tick();
        end
        idle();
        tick();

        // Reset one cycle after a granted read discards it.
        drive0(1'b0, BE_W, 8'h10, 32'h0);
        #1;
        chk("rstrd_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rstrd_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        chk("rstrd_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        chk("rstrd_ram_en", {31'h0, ram_en}, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstrd_after_rvalid", {31'h0, m0_rvalid}, 32'h0);
        tick();
        drive0(1'b0, BE_W, 8'h03, 32'h0);
        drive1(1'b0, BE_W, 8'h04, 32'h0);
        #1;
        chk("cold_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        chk("cold_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        chk("cold_wait", {28'h0, dbg_wait_cnt}, 32'h0);
        tick();
        idle();
        #1;
        chk("cold_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        chk("cold_m0_rdata", m0_rdata, 32'hC0035A03);
        chk("cold_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
